// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO (rclk domain).
// Issues read increments while there is buffer credit, captures synchronous-read
// memory data one cycle later into a 2-entry buffer, and presents a valid/ready stream.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic                  pop;
  logic                  push;
  logic [2:0]            credit_use;
  logic [1:0]            count_after_pop;

  // Stream handshake and read-credit decision; m_ready -> rinc is combinational on purpose.
  always_comb begin
    pop        = (count_q != 2'd0) & m_ready;
    push       = inflight_q;
    // Words held plus the one in flight, minus the one leaving this cycle; 3 bits, no wrap.
    credit_use = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Gated by rst_n so no increment leaks to the pointer logic while reset is held.
    rinc       = rst_n & ~empty & (credit_use < 3'd2);
  end

  // Buffer next state: shift on pop, then write the landing word behind what remains.
  always_comb begin
    buf0_d          = buf0_q;
    buf1_d          = buf1_q;
    count_after_pop = count_q - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (push) begin
      if (count_after_pop == 2'd0) begin
        buf0_d = rdata;
      end else begin
        buf1_d = rdata;
      end
    end
    count_d = count_after_pop + {1'b0, push};
  end

  // State registers; asynchronous active-low reset discards buffered and in-flight words.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
      inflight_q <= rinc;
    end
  end

  // Registered stream outputs straight from state.
  always_comb begin
    m_valid = (count_q != 2'd0);
    m_data  = buf0_q;
    level   = count_q;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: emulates the upstream FIFO and its
// synchronous-read memory, and checks every cycle against a queue-based model.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;

  logic          rclk;
  logic          rst_n;
  logic          empty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    level;

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .rclk    (rclk),
    .rst_n   (rst_n),
    .empty   (empty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .level   (level)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Model: words still in the upstream FIFO, the word being read, words held downstream.
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] held_q[$];
  bit            pend_v;
  logic [DW-1:0] pend_d;

  // Per-test statistics from observed outputs.
  int cyc, rinc_cnt, valid_cnt, first_rinc, first_valid, last_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; rinc_cnt = 0; valid_cnt = 0;
    first_rinc = -1; first_valid = -1; last_valid = -1;
  endtask

  task automatic model_reset();
    src_q.delete();
    held_q.delete();
    pend_v = 1'b0;
    pend_d = '0;
  endtask

  // One rclk cycle; entered and left at posedge+1.
  task automatic step(input bit stall, input bit ready);
    bit exp_pop, exp_rinc;
    int occ;
    empty   = stall || (src_q.size() == 0);
    m_ready = ready;
    #1;
    exp_pop  = (held_q.size() > 0) && ready;
    occ      = held_q.size() + (pend_v ? 1 : 0) - (exp_pop ? 1 : 0);
    exp_rinc = !empty && (occ < 2);
    chk("rinc", rinc, exp_rinc);
    chk("m_valid", m_valid, held_q.size() > 0);
    chk("level", level, held_q.size());
    chk("level_le2", level <= 2, 1);
    if (held_q.size() > 0) chk("m_data", m_data, held_q[0]);
    if (rinc === 1'b1) begin
      rinc_cnt++;
      if (first_rinc < 0) first_rinc = cyc;
    end
    if (m_valid === 1'b1) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end
    @(posedge rclk);
    if (exp_pop) void'(held_q.pop_front());
    if (pend_v) held_q.push_back(pend_d);
    pend_v = exp_rinc;
    if (exp_rinc) pend_d = src_q.pop_front();
    cyc++;
    #1;
    rdata = pend_v ? pend_d : DW'($urandom);
  endtask

  initial begin
    rst_n   = 1'b0;
    empty   = 1'b0;
    m_ready = 1'b1;
    rdata   = '0;
    model_reset();
    clear_stats();

    // Reset held with FIFO non-empty and downstream ready.
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_rinc", rinc, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_m_data", m_data, 0);
    rst_n = 1'b1;

    // Streaming 16 words straight out of reset, m_ready high.
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
    repeat (22) step(1'b0, 1'b1);
    chk("stream_first_rinc", first_rinc, 0);
    chk("stream_first_valid", first_valid, 2);
    chk("stream_rinc_cnt", rinc_cnt, 16);
    chk("stream_valid_cnt", valid_cnt, 16);
    chk("stream_contiguous", last_valid - first_valid, 15);

    // Single word.
    clear_stats();
    src_q.push_back(8'hA5);
    repeat (5) step(1'b0, 1'b1);
    chk("single_valid_cnt", valid_cnt, 1);
    chk("single_latency", first_valid - first_rinc, 2);
    chk("single_level_end", level, 0);

    // Backpressure: 5 stalled cycles mid-stream, then drain.
    clear_stats();
    for (int i = 0; i < 10; i++) src_q.push_back(DW'(8'h30 + i));
    repeat (3) step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    chk("bp_level_full", level, 2);
    chk("bp_rinc_held", rinc, 0);
    repeat (14) step(1'b0, 1'b1);
    chk("bp_all_delivered", held_q.size() + src_q.size() + (pend_v ? 1 : 0), 0);
    chk("bp_rinc_cnt", rinc_cnt, 10);

    // Alternating m_ready with random empty stalls and random payloads.
    clear_stats();
    for (int i = 0; i < 40; i++) src_q.push_back(DW'($urandom));
    for (int i = 0; i < 120; i++) begin
      if (i == 60) for (int j = 0; j < 20; j++) src_q.push_back(DW'($urandom));
      step(($urandom_range(0, 3) == 0), (i % 2 == 0));
    end
    repeat (8) step(1'b0, 1'b1);
    chk("alt_drained", held_q.size() + src_q.size() + (pend_v ? 1 : 0), 0);

    // Reset mid-stream while the buffer is full.
    clear_stats();
    for (int i = 0; i < 8; i++) src_q.push_back(DW'(8'hC0 + i));
    repeat (2) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    chk("pre_rst_level", level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_level", level, 0);
    model_reset();
    @(posedge rclk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 6; i++) src_q.push_back(DW'(8'h50 + i));
    repeat (10) step(1'b0, 1'b1);
    chk("post_rst_valid_cnt", valid_cnt, 6);
    chk("post_rst_first_valid", first_valid, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
